// File: rtl/demux_1_4_scheduler.sv
// Round-robin sequencer for a 1-to-4 demux: time-slices one serial source across
// the enabled outputs with a programmable dwell and blanked guard cycles on switch.
module demux_1_4_scheduler #(
    parameter int unsigned DW_W      = 4,
    parameter int unsigned GUARD_CYC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stop,
    input  logic [3:0]      chan_en,
    input  logic [DW_W-1:0] dwell,
    input  logic            d_in,
    output logic [1:0]      sel,
    output logic            d_out,
    output logic            busy,
    output logic            frame_done
);

    localparam int unsigned GW = $clog2(GUARD_CYC + 1);
    localparam int unsigned CW = (DW_W > GW) ? DW_W : GW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        GUARD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic            gate_q, gate_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;
    logic            stop_req_q, stop_req_d;
    logic [3:0]      mask_q, mask_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      nxt;
    logic            frame_end;

    function automatic logic [1:0] lowest_en(input logic [3:0] m);
        lowest_en = 2'd0;
        for (int unsigned i = 4; i > 0; i--) begin
            if (m[i-1]) lowest_en = 2'(i - 1);
        end
    endfunction

    // Circular search above cur; returns cur itself when it is the only enabled channel.
    function automatic logic [1:0] next_en(input logic [3:0] m, input logic [1:0] cur);
        logic       found;
        logic [1:0] idx;
        next_en = cur;
        found   = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = cur + 2'(i);
            if (!found && m[idx]) begin
                next_en = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign nxt       = next_en(mask_q, sel_q);
    assign frame_end = (nxt <= sel_q);

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        gate_d       = gate_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        stop_req_d   = stop_req_q | (busy_q & stop);
        mask_d       = mask_q;
        dwell_d      = dwell_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                stop_req_d = 1'b0;
                if (start && (|chan_en)) begin
                    mask_d     = chan_en;
                    dwell_d    = (dwell == '0) ? DW_W'(1) : dwell;
                    sel_d      = lowest_en(chan_en);
                    gate_d     = 1'b1;
                    busy_d     = 1'b1;
                    cnt_d      = '0;
                    stop_req_d = stop;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                gate_d = 1'b1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(dwell_q) - CW'(1)) begin
                    cnt_d        = '0;
                    frame_done_d = frame_end;
                    if (frame_end && (stop_req_q || stop)) begin
                        gate_d     = 1'b0;
                        busy_d     = 1'b0;
                        sel_d      = 2'd0;
                        stop_req_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        sel_d = nxt;
                        if (GUARD_CYC > 0) begin
                            gate_d  = 1'b0;
                            state_d = GUARD;
                        end
                    end
                end
            end
            GUARD: begin
                gate_d = 1'b0;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(GUARD_CYC - 1)) begin
                    gate_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            end
            default: begin
                state_d    = IDLE;
                sel_d      = 2'd0;
                gate_d     = 1'b0;
                busy_d     = 1'b0;
                stop_req_d = 1'b0;
                cnt_d      = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= 2'd0;
            gate_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            stop_req_q   <= 1'b0;
            mask_q       <= '0;
            dwell_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            gate_q       <= gate_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            stop_req_q   <= stop_req_d;
            mask_q       <= mask_d;
            dwell_q      <= dwell_d;
            cnt_q        <= cnt_d;
        end
    end

    assign sel        = sel_q;
    assign d_out      = d_in & gate_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_demux_1_4_scheduler.sv
// Directed bench for demux_1_4_scheduler: per-cycle expected traces are built from
// the channel mask/dwell, queued, and popped against the DUT at each falling edge.
module tb_demux_1_4_scheduler;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [3:0] chan_en;
    logic [3:0] dwell;
    logic       d_in;
    logic [1:0] sel;
    logic       d_out;
    logic       busy;
    logic       frame_done;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct packed {
        logic [1:0] sel;
        logic       gate;
        logic       busy;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];

    demux_1_4_scheduler #(.DW_W(4), .GUARD_CYC(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .chan_en    (chan_en),
        .dwell      (dwell),
        .d_in       (d_in),
        .sel        (sel),
        .d_out      (d_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected trace for nfr frames at one guard cycle per slot; the last frame ends in IDLE.
    task automatic push_run(input logic [3:0] m, input int unsigned dw, input int unsigned nfr);
        int unsigned d;
        logic [1:0]  chans[$];
        logic        last;
        exp_t        e;
        d = (dw == 0) ? 1 : dw;
        for (int unsigned c = 0; c < 4; c++) if (m[c]) chans.push_back(2'(c));
        for (int unsigned f = 0; f < nfr; f++) begin
            for (int unsigned j = 0; j < chans.size(); j++) begin
                for (int unsigned k = 0; k < d; k++) begin
                    e = '{sel: chans[j], gate: 1'b1, busy: 1'b1, fd: 1'b0};
                    exp_q.push_back(e);
                end
                last = (j == chans.size() - 1);
                if (last && (f == nfr - 1))
                    e = '{sel: 2'd0, gate: 1'b0, busy: 1'b0, fd: 1'b1};
                else
                    e = '{sel: last ? chans[0] : chans[j+1], gate: 1'b0, busy: 1'b1, fd: last};
                exp_q.push_back(e);
            end
        end
        e = '{sel: 2'd0, gate: 1'b0, busy: 1'b0, fd: 1'b0};
        exp_q.push_back(e);
        exp_q.push_back(e);
    endtask

    // Pulses start on the first cycle and stop on cycle stop_at; scrambles chan_en/dwell mid-run.
    task automatic run_trace(input string name, input int unsigned stop_at);
        int unsigned i;
        exp_t        e;
        i = 0;
        while (exp_q.size() > 0 && i < 2000) begin
            start = (i == 0);
            stop  = (i == stop_at);
            @(posedge clk);
            @(negedge clk);
            e = exp_q.pop_front();
            chk({name, "_sel"},  {2'b00, sel},   {2'b00, e.sel});
            chk({name, "_busy"}, {3'b000, busy}, {3'b000, e.busy});
            chk({name, "_fd"},   {3'b000, frame_done}, {3'b000, e.fd});
            chk({name, "_dout"}, {3'b000, d_out}, {3'b000, d_in & e.gate});
            d_in = ($urandom_range(0, 3) != 0);
            if (i == 1) begin
                chan_en = 4'($urandom);
                dwell   = 4'($urandom);
            end
            i++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL %s_timeout observed=%0d expected=0 entries left", name, exp_q.size());
            exp_q.delete();
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        chan_en = 4'b0000;
        dwell   = 4'd0;
        d_in    = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_sel",  {2'b00, sel},   4'h0);
        chk("rst_busy", {3'b000, busy}, 4'h0);
        chk("rst_dout", {3'b000, d_out}, 4'h0);
        chk("rst_fd",   {3'b000, frame_done}, 4'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: asynchronous reset in the middle of a scan
        chan_en = 4'b1111;
        dwell   = 4'd3;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("t1_busy_pre", {3'b000, busy}, 4'h1);
        chk("t1_sel_pre",  {2'b00, sel},   4'h1);
        d_in = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("t1_sel",  {2'b00, sel},   4'h0);
        chk("t1_busy", {3'b000, busy}, 4'h0);
        chk("t1_dout", {3'b000, d_out}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // T2: all four channels, dwell 3, two frames (period 16), stop in second frame
        chan_en = 4'b1111; dwell = 4'd3;
        push_run(4'b1111, 3, 2);
        run_trace("t2", 17);

        // T3: channels 1 and 3, dwell 2, period 6
        chan_en = 4'b1010; dwell = 4'd2;
        push_run(4'b1010, 2, 3);
        run_trace("t3", 13);

        // T4: single channel 2, dwell 0 treated as 1, period 2
        chan_en = 4'b0100; dwell = 4'd0;
        push_run(4'b0100, 0, 3);
        run_trace("t4", 5);

        // T5: stop pulsed during channel 1 of the first frame
        chan_en = 4'b1111; dwell = 4'd3;
        push_run(4'b1111, 3, 1);
        run_trace("t5", 5);

        // T6a: start with empty mask is ignored
        chan_en = 4'b0000; dwell = 4'd2;
        for (int unsigned k = 0; k < 3; k++) exp_q.push_back('{sel: 2'd0, gate: 1'b0, busy: 1'b0, fd: 1'b0});
        run_trace("t6a", 9999);

        // T6b: start and stop together run exactly one frame
        chan_en = 4'b0011; dwell = 4'd1;
        push_run(4'b0011, 1, 1);
        run_trace("t6b", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
